// File: rtl/lcd_bus_arbiter_pkg.sv
// lcd_arb_pkg: shared FSM states, default LCD timing and width helper for lcd_bus_arbiter
package lcd_arb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} lcd_arb_state_e;
  // Defaults for a 50 MHz clock (20 ns per cycle).
  localparam int DEF_T_SETUP = 2;
  localparam int DEF_T_PW    = 12;
  localparam int DEF_T_HOLD  = 2;
  // Bit width needed to index n items, never less than one bit.
  function automatic int lcd_arb_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/lcd_bus_arbiter_if.sv
// lcd_bus_arbiter_if: requester handshake plus LCD pin bundle for lcd_bus_arbiter
interface lcd_bus_arbiter_if import lcd_arb_pkg::*; #(
  parameter int NUM_SRC = 2,
  parameter int DATA_W  = 8
) ();
  localparam int GW = lcd_arb_w(NUM_SRC);
  logic                      lock_src0;
  logic [NUM_SRC-1:0]        req;
  logic [NUM_SRC-1:0]        rs_in;
  logic [NUM_SRC-1:0]        rw_in;
  logic [NUM_SRC*DATA_W-1:0] data_in;
  logic [NUM_SRC-1:0]        ack;
  logic [DATA_W-1:0]         rd_data;
  logic                      busy;
  logic [GW-1:0]             grant_id;
  logic [DATA_W-1:0]         lcd_din;
  logic                      lcd_rs;
  logic                      lcd_rw;
  logic                      lcd_e;
  logic [DATA_W-1:0]         lcd_data;
  modport slave (
    input  lock_src0, req, rs_in, rw_in, data_in, lcd_din,
    output ack, rd_data, busy, grant_id, lcd_rs, lcd_rw, lcd_e, lcd_data
  );
  modport master (
    output lock_src0, req, rs_in, rw_in, data_in, lcd_din,
    input  ack, rd_data, busy, grant_id, lcd_rs, lcd_rw, lcd_e, lcd_data
  );
endinterface

// File: rtl/lcd_bus_arbiter_pick.sv
// lcd_arb_pick: winner selection; LCD_ARB_ROUND_ROBIN_EN picks round-robin from ptr_i, else lowest index
module lcd_arb_pick #(
  parameter int NUM_SRC = 2,
  parameter int GW      = 1
) (
  input  logic [NUM_SRC-1:0] elig_i,
  input  logic [GW-1:0]      ptr_i,
  output logic               valid_o,
  output logic [GW-1:0]      win_o
);
  assign valid_o = |elig_i;
`ifdef LCD_ARB_ROUND_ROBIN_EN
  // Scan downward from ptr_i+N-1 so the first eligible index at or after ptr_i wins.
  always_comb begin
    win_o = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--)
      if (elig_i[(int'(ptr_i) + k) % NUM_SRC]) win_o = GW'((int'(ptr_i) + k) % NUM_SRC);
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;
  // Scan downward so the lowest eligible index wins.
  always_comb begin
    win_o = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--)
      if (elig_i[k]) win_o = GW'(k);
  end
`endif
endmodule

// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: grants one LCD requester at a time and sequences the E strobe (LCD_ARB_ROUND_ROBIN_EN in lcd_arb_pick)
module lcd_bus_arbiter import lcd_arb_pkg::*; #(
  parameter int NUM_SRC = 2,
  parameter int DATA_W  = 8,
  parameter int T_SETUP = DEF_T_SETUP,
  parameter int T_PW    = DEF_T_PW,
  parameter int T_HOLD  = DEF_T_HOLD
) (
  input  logic               clk,
  input  logic               rst_n,
  lcd_bus_arbiter_if.slave   bus
);
  localparam int GW = lcd_arb_w(NUM_SRC);
  localparam int CW = lcd_arb_w(T_SETUP + T_PW + T_HOLD);
  lcd_arb_state_e    state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              rs_q, rs_d, rw_q, rw_d, e_q, e_d;
  logic [DATA_W-1:0] data_q, data_d, rd_q, rd_d;
  logic [GW-1:0]     gid_q, gid_d, ptr_q, ptr_d, win;
  logic              win_v;
  logic [NUM_SRC-1:0] elig;
  assign elig = bus.lock_src0 ? (bus.req & NUM_SRC'(1)) : bus.req;
  lcd_arb_pick #(.NUM_SRC(NUM_SRC), .GW(GW)) u_pick (
    .elig_i (elig),
    .ptr_i  (ptr_q),
    .valid_o(win_v),
    .win_o  (win)
  );
  // State, timing counter and latched bus registers; all clear on reset so the pins drop at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      rw_q    <= 1'b0;
      e_q     <= 1'b0;
      data_q  <= '0;
      rd_q    <= '0;
      gid_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      rw_q    <= rw_d;
      e_q     <= e_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
    end
  end
  // Next state: arbitrate in IDLE, otherwise count down and reload the counter on each state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q != IDLE && cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    rs_d    = rs_q;
    rw_d    = rw_q;
    e_d     = e_q;
    data_d  = data_q;
    rd_d    = rd_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: if (win_v) begin
        state_d = SETUP;
        cnt_d   = CW'(T_SETUP - 1);
        rs_d    = bus.rs_in[win];
        rw_d    = bus.rw_in[win];
        data_d  = bus.data_in[int'(win)*DATA_W +: DATA_W];
        gid_d   = win;
        ptr_d   = (win == GW'(NUM_SRC - 1)) ? '0 : win + GW'(1);
      end
      SETUP: if (cnt_q == '0) begin
        state_d = PULSE;
        cnt_d   = CW'(T_PW - 1);
        e_d     = 1'b1;
      end
      PULSE: if (cnt_q == '0) begin
        state_d = HOLD;
        cnt_d   = CW'(T_HOLD - 1);
        e_d     = 1'b0;
        rd_d    = rw_q ? bus.lcd_din : rd_q;
      end
      default: if (cnt_q == '0) state_d = IDLE;
    endcase
  end
  assign bus.ack      = (state_q == HOLD && cnt_q == '0) ? NUM_SRC'(1) << gid_q : '0;
  assign bus.busy     = state_q != IDLE;
  assign bus.grant_id = gid_q;
  assign bus.rd_data  = rd_q;
  assign bus.lcd_rs   = rs_q;
  assign bus.lcd_rw   = rw_q;
  assign bus.lcd_e    = e_q;
  assign bus.lcd_data = data_q;
endmodule
